instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Encodes a stream of MIPS-style instruction fields into 32-bit machine words
//   and writes them into an instruction memory, one word per completed write.
//   A session is opened by a one-cycle 'start' pulse and closed by the
//   instruction marked 'in_last'. The write pointer and word count advance only
//   when the memory actually takes a word.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, base_addr      open a session and load the first write address
//   in_valid / in_ready   instruction-field handshake (see below)
//   in_last               the accepted instruction ends the session
//   mnem, rs, rt, rd,
//   shamt, funct, imm,
//   target                instruction fields
//   wr_en, wr_addr,
//   wr_data, mem_ready    registered write slot towards the memory
//   busy                  a session is active
//   done                  one-cycle pulse after the session's last write
//   err_illegal           sticky: an illegal mnemonic was accepted
//   wrapped               sticky: a write landed at address MEM_DEPTH-1
//   count                 words written in the current or last session
//
// Handshake:
//   Input side: a transfer happens on a rising edge where in_valid && in_ready.
//   in_ready is high only in LOAD and only when the output slot is empty or is
//   being emptied in the same cycle; in_ready never depends on in_valid.
//   Output side: a write completes on a rising edge where wr_en && mem_ready;
//   while wr_en && !mem_ready the slot holds wr_addr/wr_data unchanged.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [3:0]    mnem,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          err_illegal,
  output logic          wrapped,
  output logic [AW:0]   count
);

  // Saturation value for count; fits because count is one bit wider than AW.
  localparam logic [AW:0]   COUNT_MAX = (AW+1)'(MEM_DEPTH);
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [AW-1:0] r_ptr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic [AW:0]   r_count;
  logic          r_err;
  logic          r_wrapped;
  logic          r_done;

  logic          w_in_ready;
  logic          w_hs;
  logic          w_wr_done;
  logic          w_start_go;
  logic          w_flush_empty;
  logic          w_legal;
  logic [31:0]   w_word;
  logic [AW-1:0] w_slot_addr;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign w_wr_done     = r_wr_en && mem_ready;
  assign w_in_ready    = (r_state == S_LOAD) && (!r_wr_en || mem_ready);
  assign w_hs          = in_valid && w_in_ready;
  assign w_start_go    = (r_state == S_IDLE) && start;
  // In FLUSH the slot is (or becomes) empty this cycle: nothing pending, or the
  // pending word is being taken right now.
  assign w_flush_empty = (r_state == S_FLUSH) && (!r_wr_en || mem_ready);

  // An instruction accepted in the same cycle that the previous word completes
  // must take the address after that word, since the pointer only moves on
  // completion.
  assign w_slot_addr   = w_wr_done ? (r_ptr + ADDR_ONE) : r_ptr;

  // ---------------------------------------------------------------------------
  // Instruction encoder
  // ---------------------------------------------------------------------------
  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b1;
    case (mnem)
      4'd0:    w_word = {6'b000000, rs, rt, rd, shamt, funct};  // R-type
      4'd1:    w_word = {6'b001000, rs, rt, imm};               // addi
      4'd2:    w_word = {6'b001111, 5'b00000, rt, imm};         // lui (rs forced 0)
      4'd3:    w_word = {6'b001101, rs, rt, imm};               // ori
      4'd4:    w_word = {6'b001100, rs, rt, imm};               // andi
      4'd5:    w_word = {6'b001110, rs, rt, imm};               // xori
      4'd6:    w_word = {6'b100011, rs, rt, imm};               // lw
      4'd7:    w_word = {6'b101011, rs, rt, imm};               // sw
      4'd8:    w_word = {6'b000100, rs, rt, imm};               // beq
      4'd9:    w_word = {6'b000101, rs, rt, imm};               // bne
      4'd10:   w_word = {6'b000010, target};                    // j
      4'd11:   w_word = {6'b000011, target};                    // jal
      default: w_legal = 1'b0;                                  // 12..15
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs && in_last) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // An illegal last instruction never fills the slot, so this exits on
        // the very next cycle in that case.
        if (w_flush_empty) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
    end else begin
      if (w_hs && w_legal) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_slot_addr;
        r_wr_data <= w_word;
      end else if (w_wr_done) begin
        r_wr_en   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer, count and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (w_start_go) begin
      r_ptr     <= base_addr;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_wr_done) begin
        // MEM_DEPTH is a power of two, so the AW-bit add wraps modulo depth.
        r_ptr <= r_ptr + ADDR_ONE;
        if (r_count != COUNT_MAX) begin
          r_count <= r_count + (AW+1)'(1);
        end
        if (r_wr_addr == ADDR_LAST) begin
          r_wrapped <= 1'b1;
        end
      end
      if (w_hs && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Session-complete pulse: registered so it lines up with the final count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_flush_empty;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = w_in_ready;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err_illegal = r_err;
  assign wrapped     = r_wrapped;
  assign count       = r_count;

endmodule
